// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline writeback, long-unit results, hazard query
// and the registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          pipe_wen;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic          lu_valid;
  logic [AW-1:0] lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic          lu_ready;
  logic [AW-1:0] query_addr;
  logic          query_hit;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport slave (
    input  pipe_wen, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, query_addr,
    output pipe_stall, lu_ready, query_hit, rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_wen, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata, query_addr,
    input  pipe_stall, lu_ready, query_hit, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the in-order writeback and a
// long-latency unit buffered in a 2-entry FIFO; stalls the pipe to drain it.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  wb_port_arbiter_if.slave   bus
);
  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_hit;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count, count_nxt;

  logic             grant_pipe, pop, push, squash, stall;
  logic             rf_wen_q;
  logic [AW-1:0]    rf_waddr_q;
  logic [DW-1:0]    rf_wdata_q;

  // Pipe wins whenever it is not being held; the FIFO only drains into idle slots.
  assign grant_pipe = (state == NORMAL) && bus.pipe_wen;
  assign pop        = !grant_pipe && (count != 2'd0);
  assign push       = bus.lu_valid && bus.lu_ready;
  assign squash     = grant_pipe && (bus.pipe_waddr != '0);
  assign count_nxt  = count + {1'b0, push} - {1'b0, pop};

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign ent_hit[i] = ent_vld[i] && (ent_addr[i] == bus.query_addr);
  end

  assign bus.lu_ready   = (count < FULL);
  assign bus.query_hit  = (|ent_hit) && (bus.query_addr != '0);
  assign bus.pipe_stall = stall;
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= NORMAL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      NORMAL: if (count_nxt == FULL) state_nxt = DRAIN;
      DRAIN: begin
        stall = 1'b1;
        if (count_nxt == 2'd0) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Squash/pop clear slots before push fills one, so a same-cycle enqueue survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (squash)
        for (int i = 0; i < DEPTH; i++)
          if (ent_addr[i] == bus.pipe_waddr) ent_vld[i] <= 1'b0;
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ~rd_ptr;
      end
      if (push) begin
        ent_vld[wr_ptr]  <= 1'b1;
        ent_addr[wr_ptr] <= bus.lu_waddr;
        ent_data[wr_ptr] <= bus.lu_wdata;
        wr_ptr           <= ~wr_ptr;
      end
      count <= count_nxt;
    end
  end

  // Writes to $0 and squashed entries still use the slot but never assert rf_wen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (grant_pipe) begin
      rf_wen_q   <= (bus.pipe_waddr != '0);
      rf_waddr_q <= bus.pipe_waddr;
      rf_wdata_q <= bus.pipe_wdata;
    end else if (pop) begin
      rf_wen_q   <= ent_vld[rd_ptr] && (ent_addr[rd_ptr] != '0);
      rf_waddr_q <= ent_addr[rd_ptr];
      rf_wdata_q <= ent_data[rd_ptr];
    end else begin
      rf_wen_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed check of wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;

  wb_port_arbiter_if #(.AW(5), .DW(32)) bus ();

  wb_port_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        q[$];
  bit          drain;
  bit          stalled_last;
  bit          exp_wen;
  logic [4:0]  exp_a;
  logic [31:0] exp_d;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [4:0] qa);
    bit h = 1'b0;
    foreach (q[i]) if (q[i].v && q[i].a == qa) h = 1'b1;
    return h && (qa != 5'd0);
  endfunction

  // Writeback holds its request for every stalled cycle after the first.
  task automatic drive(input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] qa);
    if (!stalled_last) begin
      bus.pipe_wen   = pw;
      bus.pipe_waddr = pa;
      bus.pipe_wdata = pd;
    end
    bus.lu_valid   = lv;
    bus.lu_waddr   = la;
    bus.lu_wdata   = ld;
    bus.query_addr = qa;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    bit   gp;
    bit   push;
    ent_t e;
    #1;
    chk({tag, "_stall"}, bus.pipe_stall, drain);
    chk({tag, "_ready"}, bus.lu_ready, q.size() < 2);
    chk({tag, "_hit"}, bus.query_hit, model_hit(bus.query_addr));
    stalled_last = drain;
    gp   = !drain && bus.pipe_wen;
    push = bus.lu_valid && (q.size() < 2);
    exp_wen = 1'b0;
    if (gp) begin
      exp_wen = (bus.pipe_waddr != 5'd0);
      exp_a   = bus.pipe_waddr;
      exp_d   = bus.pipe_wdata;
      if (bus.pipe_waddr != 5'd0)
        foreach (q[i]) if (q[i].a == bus.pipe_waddr) q[i].v = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_wen = e.v && (e.a != 5'd0);
      exp_a   = e.a;
      exp_d   = e.d;
    end
    if (push) q.push_back('{a: bus.lu_waddr, d: bus.lu_wdata, v: 1'b1});
    if (!drain && q.size() == 2)     drain = 1'b1;
    else if (drain && q.size() == 0) drain = 1'b0;
    @(posedge clock);
    #1;
    chk({tag, "_wen"}, bus.rf_wen, exp_wen);
    if (exp_wen) begin
      chk({tag, "_waddr"}, bus.rf_waddr, exp_a);
      chk({tag, "_wdata"}, bus.rf_wdata, exp_d);
    end
    @(negedge clock);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    bus.query_addr = 5'd9;
    #1;
    chk("rst_wen", bus.rf_wen, 1'b0);
    chk("rst_waddr", bus.rf_waddr, 5'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_stall", bus.pipe_stall, 1'b0);
    chk("rst_ready", bus.lu_ready, 1'b1);
    chk("rst_hit", bus.query_hit, 1'b0);
    q.delete();
    drain = 1'b0;
    stalled_last = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    drain = 1'b0;
    stalled_last = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    async_reset();

    // Plain pipe writes, then a pipe write to $0.
    drive(1, 5'd8, 32'h1234, 0, 0, 0, 0); step("p2");
    chk("p2_const", bus.rf_wdata, 32'h1234);
    drive(1, 5'd0, 32'h5678, 0, 0, 0, 0); step("p2z");

    // Long-unit pulse with idle pipe: two-cycle latency.
    drive(0, 0, 0, 1, 5'd3, 32'hDEAD, 5'd3); step("p3a");
    drive(0, 0, 0, 0, 0, 0, 5'd3);            step("p3b");
    chk("p3_const", bus.rf_waddr, 5'd3);
    // Long-unit result deferred behind a busy pipe.
    drive(1, 5'd1, 32'h11, 1, 5'd7, 32'h77, 5'd7); step("p3c");
    drive(1, 5'd2, 32'h22, 0, 0, 0, 5'd7);         step("p3d");
    drive(0, 0, 0, 0, 0, 0, 5'd7);                 step("p3e");

    // Fill FIFO under a busy pipe, drain, then the held pipe write.
    drive(1, 5'd1, 32'h11, 1, 5'd4, 32'h44, 0); step("p4a");
    drive(1, 5'd2, 32'h22, 1, 5'd5, 32'h55, 0); step("p4b");
    chk("p4_stall", bus.pipe_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd6, 32'h66, 0, 0, 0, 5'd5); step("p4d");
    end
    drive(0, 0, 0, 0, 0, 0, 0); step("p4e");

    // WAW squash: younger pipe write kills the buffered r9.
    drive(1, 5'd1, 32'h11, 1, 5'd9, 32'h1, 5'd9); step("p5a");
    drive(1, 5'd9, 32'h2, 0, 0, 0, 5'd9);         step("p5b");
    drive(0, 0, 0, 0, 0, 0, 5'd9);                step("p5c");
    chk("p5_stale", bus.rf_wen, 1'b0);

    // count==1 with simultaneous push and pop keeps order.
    drive(1, 5'd1, 32'h11, 1, 5'd10, 32'hA, 5'd10); step("p6a");
    drive(0, 0, 0, 1, 5'd11, 32'hB, 5'd0);          step("p6b");
    drive(0, 0, 0, 0, 0, 0, 5'd11);                 step("p6c");
    drive(0, 0, 0, 0, 0, 0, 5'd0);                  step("p6d");

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
      step("rnd");
      if (n == 1500) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
